// File: rtl/decode_align_ctrl_pkg.sv
// decode_align_ctrl_pkg: shared line geometry and FSM encoding for the D-stage window
package decode_align_ctrl_pkg;
  localparam int LINE_BYTES = 16;
  localparam int MAX_INSTR_LEN = 15;
  typedef enum logic [1:0] {FILL_A, FILL_B, RUN, DROP} state_t;
endpackage

// File: rtl/decode_align_ctrl_byte_rotator.sv
// decode_align_ctrl_byte_rotator: two-level byte rotator over the two-line window source
module decode_align_ctrl_byte_rotator
  import decode_align_ctrl_pkg::*;
(
  input  logic [8*(LINE_BYTES+MAX_INSTR_LEN)-1:0] d,
  input  logic [3:0]                              s,
  output logic [8*LINE_BYTES-1:0]                 q
);
  localparam int W = 8*LINE_BYTES;
  logic [W+95:0] t;
  // Fine stage shifts by 0..3 bytes, coarse stage by 0..3 four-byte words
  always_comb begin
    t = s[1:0] == 2'd0 ? d[W+95:0] : s[1:0] == 2'd1 ? d[W+103:8] : s[1:0] == 2'd2 ? d[W+111:16] : d[W+119:24];
    q = s[3:2] == 2'd0 ? t[W-1:0] : s[3:2] == 2'd1 ? t[W+31:32] : s[3:2] == 2'd2 ? t[W+63:64] : t[W+95:96];
  end
endmodule

// File: rtl/decode_align_ctrl.sv
// decode_align_ctrl: two-line fetch window sequencer; DECODE_ALIGN_PERF_EN adds perf counters
module decode_align_ctrl
  import decode_align_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [31:0]  flush_eip,
  output logic         fetch_req,
  output logic [31:0]  fetch_addr,
  input  logic         fetch_valid,
  input  logic [127:0] fetch_data,
  output logic         dec_valid,
  input  logic         dec_ready,
  input  logic [3:0]   dec_len,
  output logic [127:0] dec_bytes,
  output logic [31:0]  dec_eip
`ifdef DECODE_ALIGN_PERF_EN
  ,
  output logic [31:0]  perf_instr,
  output logic [31:0]  perf_stall
`endif
);
  state_t       state;
  logic [127:0] a, b, rot;
  logic         va, vb, consume, carry, fill, va_n, vb_n;
  logic [3:0]   ptr;
  logic [27:0]  line_a, nxt_line;
  logic [4:0]   sum;
  assign dec_valid = va & vb & (state != DROP);
  assign fetch_addr = {nxt_line, 4'h0};
  assign dec_eip = {line_a, ptr};
  assign dec_bytes = va ? rot : '0;
  // B's last byte is never reachable by a shift of at most 15, so it stays out of the rotator
  decode_align_ctrl_byte_rotator u_rot (
    .d({b[8*MAX_INSTR_LEN-1:0], a}),
    .s(ptr),
    .q(rot)
  );
  // Advance arithmetic and slot occupancy after this cycle's consume and fill
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, dec_len};
    consume = dec_valid & dec_ready;
    carry = consume & sum[4];
    fill = fetch_valid & (~va | ~vb | carry);
    va_n = va | fill;
    vb_n = carry ? fill : vb | (fill & va);
  end
  // Window sequencing FSM: reset, redirect, in-flight discard, then normal consume/fill
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FILL_A;
      va <= 1'b0;
      vb <= 1'b0;
      ptr <= RESET_EIP[3:0];
      line_a <= RESET_EIP[31:4];
      nxt_line <= RESET_EIP[31:4];
      fetch_req <= 1'b0;
      a <= '0;
      b <= '0;
    end else if (flush) begin
      va <= 1'b0;
      vb <= 1'b0;
      ptr <= flush_eip[3:0];
      line_a <= flush_eip[31:4];
      nxt_line <= flush_eip[31:4];
      fetch_req <= 1'b1;
      state <= fetch_req & ~fetch_valid ? DROP : FILL_A;
    end else if (state == DROP) begin
      if (fetch_valid) state <= FILL_A;
    end else begin
      if (consume) ptr <= sum[3:0];
      if (carry) line_a <= line_a + 28'd1;
      if (fill) nxt_line <= nxt_line + 28'd1;
      if (carry) a <= b;
      else if (fill & ~va) a <= fetch_data;
      if (fill & (va | carry)) b <= fetch_data;
      va <= va_n;
      vb <= vb_n;
      fetch_req <= ~(va_n & vb_n);
      state <= ~va_n ? FILL_A : ~vb_n ? FILL_B : RUN;
    end
  end
`ifdef DECODE_ALIGN_PERF_EN
  // Count accepted instructions and cycles without a valid window
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_instr <= '0;
      perf_stall <= '0;
    end else begin
      if (consume & ~flush) perf_instr <= perf_instr + 32'd1;
      if (~dec_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_align_ctrl.sv
// tb_decode_align_ctrl: table vectors plus scoreboarded window/fetch checks for decode_align_ctrl
module tb_decode_align_ctrl;
  import decode_align_ctrl_pkg::*;
  localparam logic [31:0] RST_EIP = 32'h0000_1000;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, fetch_valid = 1'b0, dec_ready = 1'b0;
  logic [31:0] flush_eip = '0;
  logic [127:0] fetch_data = '0;
  logic [3:0] dec_len = '0;
  logic fetch_req, dec_valid;
  logic [31:0] fetch_addr, dec_eip;
  logic [127:0] dec_bytes;
`ifdef DECODE_ALIGN_PERF_EN
  logic [31:0] perf_instr, perf_stall;
`endif
  int n_vec = 0, n_bad = 0, age = 0, accepts = 0;
  logic force_fv = 1'b0, mdrop = 1'b0;
  logic [27:0] exp_line = '0;
  logic [31:0] eip_q[$];

  decode_align_ctrl #(.RESET_EIP(RST_EIP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_eip(flush_eip),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_len(dec_len), .dec_bytes(dec_bytes), .dec_eip(dec_eip)
`ifdef DECODE_ALIGN_PERF_EN
    , .perf_instr(perf_instr), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] ad);
    return ad[7:0] ^ {ad[11:8], ad[15:12]} ^ 8'h5a;
  endfunction

  function automatic logic [127:0] window(input logic [31:0] e);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = mem_byte(e + 32'(i));
    return w;
  endfunction

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic tick();
    logic acc;
    int age_n;
    logic [31:0] e;
    fetch_valid = force_fv | (fetch_req && age >= 1);
    fetch_data = window(fetch_addr);
    if (dec_valid && eip_q.size() > 0) begin
      chk("win_eip", dec_eip, eip_q[0]);
      chk("win_bytes", dec_bytes, window(eip_q[0]));
    end
    if (!rst) begin
      eip_q.delete();
      eip_q.push_back(RST_EIP);
      exp_line = RST_EIP[31:4];
      mdrop = 1'b0;
    end else if (flush) begin
      mdrop = fetch_req && !fetch_valid;
      eip_q.delete();
      eip_q.push_back(flush_eip);
      exp_line = flush_eip[31:4];
    end else begin
      if (fetch_valid) begin
        if (mdrop) mdrop = 1'b0;
        else begin
          chk("fetch_addr", fetch_addr, {exp_line, 4'h0});
          exp_line = exp_line + 28'd1;
          accepts++;
        end
      end
      if (dec_valid && dec_ready) begin
        e = eip_q.pop_front();
        eip_q.push_back(e + 32'(dec_len));
      end
    end
    acc = fetch_valid;
    age_n = (!rst || acc || !fetch_req) ? 0 : age + 1;
    @(posedge clk);
    age = age_n;
    #1;
    fetch_valid = 1'b0;
    force_fv = 1'b0;
  endtask

  task automatic wait_valid(input string n);
    int k = 0;
    while (!dec_valid && k < 20) begin
      tick();
      k++;
    end
    n_vec++;
    if (!dec_valid) begin
      n_bad++;
      $display("FAIL %s: dec_valid still 0 after %0d cycles, want 1", n, k);
    end
  endtask

  task automatic consume(input logic [3:0] len);
    dec_ready = 1'b1;
    dec_len = len;
    tick();
    dec_ready = 1'b0;
    dec_len = '0;
  endtask

  task automatic do_flush(input logic [31:0] t);
    flush = 1'b1;
    flush_eip = t;
    tick();
    flush = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  len;
    logic [31:0] eip;
    logic        valid;
    logic        req;
    logic [31:0] addr;
  } vec_t;
  vec_t tv[4];

  initial begin
    int a0;
    tv[0] = '{4'd3, 32'h1003, 1'b1, 1'b0, 32'h0};
    tv[1] = '{4'd5, 32'h1008, 1'b1, 1'b0, 32'h0};
    tv[2] = '{4'd7, 32'h100F, 1'b1, 1'b0, 32'h0};
    tv[3] = '{4'd1, 32'h1010, 1'b0, 1'b1, 32'h1020};
    #1;
    tick();
    tick();
    chk("rst_req", fetch_req, 1'b0);
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_eip", dec_eip, RST_EIP);
    chk("rst_bytes", dec_bytes, 128'h0);
    rst = 1'b1;
    tick();
    chk("first_req", fetch_req, 1'b1);
    chk("first_addr", fetch_addr, 32'h1000);
    for (int i = 0; i < 4; i++) begin
      wait_valid("tv_wait");
      consume(tv[i].len);
      chk("tv_eip", dec_eip, tv[i].eip);
      chk("tv_valid", dec_valid, tv[i].valid);
      chk("tv_req", fetch_req, tv[i].req);
      if (tv[i].req) chk("tv_addr", fetch_addr, tv[i].addr);
    end
    wait_valid("stall_wait");
    a0 = accepts;
    repeat (10) tick();
    chk("stall_eip", dec_eip, 32'h1010);
    chk("stall_bytes", dec_bytes, window(32'h1010));
    chk("stall_req", fetch_req, 1'b0);
    chk("stall_fetches", 32'(accepts - a0), 32'd0);
`ifdef DECODE_ALIGN_PERF_EN
    chk("perf_instr", perf_instr, 32'd4);
`endif
    consume(4'd15);
    chk("ptr15_eip", dec_eip, 32'h101F);
    force_fv = 1'b1;
    consume(4'd2);
    chk("coin_valid", dec_valid, 1'b1);
    chk("coin_eip", dec_eip, 32'h1021);
    chk("coin_bytes", dec_bytes, window(32'h1021));
    chk("coin_req", fetch_req, 1'b0);
    consume(4'd15);
    chk("pre_flush_req", fetch_req, 1'b1);
    do_flush(32'h2007);
    chk("drop_valid", dec_valid, 1'b0);
    chk("drop_req", fetch_req, 1'b1);
    wait_valid("flush_wait");
    chk("flush_eip", dec_eip, 32'h2007);
    chk("flush_byte0", dec_bytes[7:0], mem_byte(32'h2007));
    do_flush(32'h300F);
    wait_valid("wrap15_wait");
    consume(4'd15);
    chk("wrap15_eip", dec_eip, 32'h301E);
    chk("wrap15_valid", dec_valid, 1'b0);
    wait_valid("wrap15_refill");
    rst = 1'b0;
    flush = 1'b1;
    flush_eip = 32'h4000;
    dec_ready = 1'b1;
    dec_len = 4'd3;
    force_fv = 1'b1;
    tick();
    flush = 1'b0;
    dec_ready = 1'b0;
    dec_len = '0;
    chk("midrst_eip", dec_eip, RST_EIP);
    chk("midrst_valid", dec_valid, 1'b0);
    chk("midrst_req", fetch_req, 1'b0);
    chk("midrst_bytes", dec_bytes, 128'h0);
    rst = 1'b1;
    tick();
    chk("midrst_addr", fetch_addr, 32'h1000);
    wait_valid("midrst_wait");
    do_flush(32'hFFFF_FFF8);
    wait_valid("lwrap_wait");
    consume(4'd10);
    chk("lwrap_eip", dec_eip, 32'h0000_0002);
    wait_valid("lwrap_refill");
    consume(4'd1);
    chk("lwrap_next", dec_eip, 32'h0000_0003);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
